// File: rtl/fpga_board_pkg.sv
// rtl/fpga_board_pkg.sv - shared types for the board I/O conditioning block
package fpga_board_pkg;

    typedef enum logic [1:0] {
        PM_PASS  = 2'd0,
        PM_SWAP  = 2'd1,
        PM_TEST  = 2'd2,
        PM_BLANK = 2'd3
    } pmod_mode_e;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } rst_state_e;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - one button channel: synchroniser, debounce counter, press pulse
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    // Raw input is active-low; flip it so 1 means pressed from here on.
    assign synced = ~sync_q[SYNC_STAGES-1];

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
                press_d  = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - button conditioning, core reset sequencing, PMOD mapper and status LEDs
module board_io_ctrl
    import fpga_board_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RST_STRETCH     = 1024,
    parameter int PMOD_W          = 8,
    parameter int TEST_DIV        = 25000000,
    parameter int HEARTBEAT_HALF  = 12500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked_i,
    input  logic [NUM_BTN-1:0] btn_n_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic               core_rst_n_o,
    input  logic [1:0]         mode_i,
    input  logic [PMOD_W-1:0]  core_out_i,
    output logic [PMOD_W-1:0]  pmod_o,
    output logic               led_r_n_o,
    output logic               led_g_n_o
);
    localparam int HALF = PMOD_W / 2;
    localparam int SW   = $clog2(RST_STRETCH) + 1;
    localparam int DW   = $clog2(TEST_DIV) + 1;
    localparam int HW   = $clog2(HEARTBEAT_HALF) + 1;
    localparam logic [SW-1:0]     ST_LAST   = SW'(RST_STRETCH - 1);
    localparam logic [DW-1:0]     DIV_LAST  = DW'(TEST_DIV - 1);
    localparam logic [HW-1:0]     HB_LAST   = HW'(HEARTBEAT_HALF - 1);
    localparam logic [PMOD_W-1:0] PAT_FIRST = {{(PMOD_W-1){1'b0}}, 1'b1};

    logic [NUM_BTN-1:0]     btn_level;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   lock_ok;

    rst_state_e             state_q, state_d;
    logic [SW-1:0]          st_cnt_q, st_cnt_d;
    logic                   core_rst_n_q, core_rst_n_d;

    pmod_mode_e             mode, mode_q;
    logic [PMOD_W-1:0]      pat_q, pat_d;
    logic [DW-1:0]          div_q, div_d;
    logic [PMOD_W-1:0]      pmod_q, pmod_d;

    logic [HW-1:0]          hb_cnt_q, hb_cnt_d;
    logic                   led_g_q, led_g_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .btn_n_i(btn_n_i[i]),
            .level_o(btn_level[i]),
            .press_o(btn_press_o[i])
        );
    end

    assign btn_level_o = btn_level;
    assign lock_ok     = lock_sync_q[SYNC_STAGES-1] && !btn_level[0];

    // Lock loss is checked before the terminal count so HOLD wins a tie.
    always_comb begin
        state_d  = state_q;
        st_cnt_d = '0;
        case (state_q)
            HOLD:    if (lock_ok) state_d = STRETCH;
            STRETCH: begin
                if (!lock_ok)                state_d = HOLD;
                else if (st_cnt_q == ST_LAST) state_d = RUN;
                else                         st_cnt_d = st_cnt_q + 1'b1;
            end
            RUN:     if (!lock_ok) state_d = HOLD;
            default: state_d = HOLD;
        endcase
        core_rst_n_d = (state_d == RUN);
    end

    assign mode = pmod_mode_e'(mode_i);

    always_comb begin
        pat_d  = pat_q;
        div_d  = div_q;
        pmod_d = '0;
        if (mode == PM_TEST) begin
            if (mode_q != PM_TEST) begin
                pat_d = PAT_FIRST;
                div_d = '0;
            end else if (div_q == DIV_LAST) begin
                div_d = '0;
                pat_d = {pat_q[PMOD_W-2:0], pat_q[PMOD_W-1]};
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        case (mode)
            PM_PASS: pmod_d = core_out_i;
            PM_SWAP: pmod_d = {core_out_i[HALF-1:0], core_out_i[PMOD_W-1:HALF]};
            PM_TEST: pmod_d = pat_d;
            default: pmod_d = '0;
        endcase
        // Gate with the next reset value so pins and core reset change together.
        if (!core_rst_n_d) pmod_d = '0;
    end

    // The heartbeat starts counting on the first full cycle in RUN.
    always_comb begin
        hb_cnt_d = '0;
        led_g_d  = 1'b1;
        if (core_rst_n_d) begin
            led_g_d = led_g_q;
            if (core_rst_n_q) begin
                if (hb_cnt_q == HB_LAST) led_g_d = ~led_g_q;
                else                     hb_cnt_d = hb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync_q  <= '0;
            state_q      <= HOLD;
            st_cnt_q     <= '0;
            core_rst_n_q <= 1'b0;
            mode_q       <= PM_PASS;
            pat_q        <= PAT_FIRST;
            div_q        <= '0;
            pmod_q       <= '0;
            hb_cnt_q     <= '0;
            led_g_q      <= 1'b1;
        end else begin
            lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
            state_q      <= state_d;
            st_cnt_q     <= st_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            mode_q       <= mode;
            pat_q        <= pat_d;
            div_q        <= div_d;
            pmod_q       <= pmod_d;
            hb_cnt_q     <= hb_cnt_d;
            led_g_q      <= led_g_d;
        end
    end

    assign core_rst_n_o = core_rst_n_q;
    assign pmod_o       = pmod_q;
    assign led_r_n_o    = core_rst_n_q;
    assign led_g_n_o    = led_g_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - directed self-checking bench for board_io_ctrl
module tb_board_io_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked_i;
    logic [1:0] btn_n_i;
    logic [1:0] btn_level_o;
    logic [1:0] btn_press_o;
    logic       core_rst_n_o;
    logic [1:0] mode_i;
    logic [7:0] core_out_i;
    logic [7:0] pmod_o;
    logic       led_r_n_o;
    logic       led_g_n_o;

    int         checks = 0;
    int         errors = 0;
    int         n;
    int         presses;
    int         first;
    logic       seen;
    logic [7:0] exp_pat;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .NUM_BTN        (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RST_STRETCH    (8),
        .PMOD_W         (8),
        .TEST_DIV       (2),
        .HEARTBEAT_HALF (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked_i(pll_locked_i),
        .btn_n_i     (btn_n_i),
        .btn_level_o (btn_level_o),
        .btn_press_o (btn_press_o),
        .core_rst_n_o(core_rst_n_o),
        .mode_i      (mode_i),
        .core_out_i  (core_out_i),
        .pmod_o      (pmod_o),
        .led_r_n_o   (led_r_n_o),
        .led_g_n_o   (led_g_n_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_rst_n(input logic val, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (core_rst_n_o !== val && cnt < 60);
    endtask

    task automatic wait_led_g(input logic val, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (led_g_n_o !== val && cnt < 60);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pll_locked_i = 1'b0; btn_n_i = 2'b11; mode_i = 2'd0; core_out_i = 8'h00;
        cyc(3);
        check("rst_level", btn_level_o, 2'b00);
        check("rst_press", btn_press_o, 2'b00);
        check("rst_core", core_rst_n_o, 1'b0);
        check("rst_pmod", pmod_o, 8'h00);
        check("rst_led_r", led_r_n_o, 1'b0);
        check("rst_led_g", led_g_n_o, 1'b1);

        rst = 1'b0; pll_locked_i = 1'b1;
        wait_rst_n(1'b1, n);
        check("startup_latency", n, 11);
        check("led_r_run", led_r_n_o, 1'b1);
        check("led_g_start", led_g_n_o, 1'b1);
        wait_led_g(1'b0, n);
        check("hb_first_toggle", n, 4);
        wait_led_g(1'b1, n);
        check("hb_second_toggle", n, 4);

        core_out_i = 8'hA5; mode_i = 2'd0; cyc(1);
        check("pm_pass", pmod_o, 8'hA5);
        mode_i = 2'd1; cyc(1);
        check("pm_swap", pmod_o, 8'h5A);
        mode_i = 2'd3; cyc(1);
        check("pm_blank", pmod_o, 8'h00);
        mode_i = 2'd2;
        for (int k = 0; k < 18; k++) begin
            cyc(1);
            exp_pat = 8'h01;
            exp_pat = exp_pat << ((k / 2) % 8);
            check("pm_walk", pmod_o, exp_pat);
        end
        mode_i = 2'd0; cyc(1);
        check("pm_pass_again", pmod_o, 8'hA5);
        mode_i = 2'd2; cyc(1);
        check("pm_reenter_0", pmod_o, 8'h01);
        cyc(1);
        check("pm_reenter_1", pmod_o, 8'h01);
        cyc(1);
        check("pm_reenter_2", pmod_o, 8'h02);

        btn_n_i = 2'b01; cyc(3); btn_n_i = 2'b11;
        seen = 1'b0;
        repeat (12) begin
            cyc(1);
            seen = seen | btn_level_o[1] | btn_press_o[1];
        end
        check("glitch_3", seen, 1'b0);

        btn_n_i = 2'b01; first = 0; presses = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            if (btn_press_o[1]) presses++;
            if (btn_level_o[1] && first == 0) begin
                first = k;
                check("press_with_level", btn_press_o[1], 1'b1);
            end
        end
        btn_n_i = 2'b11;
        repeat (12) begin
            cyc(1);
            if (btn_press_o[1]) presses++;
        end
        check("btn_latency", first, 6);
        check("press_count", presses, 1);
        check("btn_released", btn_level_o[1], 1'b0);
        check("core_unaffected", core_rst_n_o, 1'b1);

        pll_locked_i = 1'b0;
        wait_rst_n(1'b0, n);
        check("lock_loss_latency", n, 3);
        check("lock_loss_led_g", led_g_n_o, 1'b1);
        check("lock_loss_pmod", pmod_o, 8'h00);
        cyc(5);

        pll_locked_i = 1'b1; cyc(6); pll_locked_i = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            cyc(1);
            seen = seen | core_rst_n_o;
        end
        check("abort_at_5", seen, 1'b0);

        pll_locked_i = 1'b1; cyc(8); pll_locked_i = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            cyc(1);
            seen = seen | core_rst_n_o;
        end
        check("hold_wins_terminal", seen, 1'b0);

        pll_locked_i = 1'b1;
        wait_rst_n(1'b1, n);
        check("restretch_latency", n, 11);

        btn_n_i = 2'b10;
        wait_rst_n(1'b0, n);
        check("btn0_latency", n, 7);
        check("btn0_level", btn_level_o[0], 1'b1);
        check("btn0_led_g", led_g_n_o, 1'b1);
        check("btn0_led_r", led_r_n_o, 1'b0);
        check("btn0_pmod", pmod_o, 8'h00);
        btn_n_i = 2'b11;
        wait_rst_n(1'b1, n);
        check("btn0_release_latency", n, 15);

        mode_i = 2'd0; cyc(1);
        check("run_pass", pmod_o, 8'hA5);
        btn_n_i = 2'b01; cyc(8);
        check("pre_rst_level", btn_level_o[1], 1'b1);
        rst = 1'b1; cyc(1);
        check("midrst_level", btn_level_o, 2'b00);
        check("midrst_press", btn_press_o, 2'b00);
        check("midrst_core", core_rst_n_o, 1'b0);
        check("midrst_pmod", pmod_o, 8'h00);
        check("midrst_led_r", led_r_n_o, 1'b0);
        check("midrst_led_g", led_g_n_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
